// File: rtl/vsr_pkg.sv
// Shared definitions for the vector scalar reduce/pack pipeline.
// Firmware mode encodings and width helpers.
package vsr_pkg;

  localparam logic [7:0] FW_PASS = 8'd0;
  localparam logic [7:0] FW_PACK = 8'd1;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int id_w(input int chains);
    return (chains > 1) ? $clog2(chains) : 1;
  endfunction

endpackage

// File: rtl/scalar_pack_buffer.sv
// Per-chain scalar accumulator for the pack unit.
// Keeps pending scalars and the current fill level of one chain.
module scalar_pack_buffer
  import vsr_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = cnt_w(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         store,
  input  logic                         emit,
  input  logic                         restart,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        data,
  output logic [CW-1:0]                cnt,
  output logic [N-1:0][DATA_WIDTH-1:0] elems
);

  logic [CW-1:0]                cnt_q;
  logic [CW-1:0]                idx;
  logic [N-1:0][DATA_WIDTH-1:0] mem_q;

  // A begin-of-frame drops the stale partial before this store
  assign idx   = restart ? '0 : cnt_q;
  assign cnt   = cnt_q;
  assign elems = mem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      mem_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (store) begin
      if (emit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= idx + CW'(1);
        // Top slot is never written; an emitting store bypasses it
        for (int i = 0; i < N - 1; i++) begin
          if (idx == CW'(i)) mem_q[i] <= data;
        end
      end
    end else if (flush) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/vector_scalar_pack_unit.sv
// Packs zero-padded scalars from the reduce unit into dense vectors.
// Per-chain firmware selects pass-through or pack mode.
module vector_scalar_pack_unit
  import vsr_pkg::*;
#(
  parameter int                      N                  = 8,
  parameter int                      DATA_WIDTH         = 32,
  parameter int                      MAX_CHAINS         = 4,
  parameter int                      PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
  parameter int                      CW                 = cnt_w(N),
  parameter int                      IW                 = id_w(MAX_CHAINS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic                         eof_in,
  input  logic                         bof_in,
  input  logic [IW-1:0]                chainId_in,
  input  logic                         tracing,
  input  logic [7:0]                   configId,
  input  logic [7:0]                   configData,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  output logic                         valid_out,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic [CW-1:0]                count_out,
  output logic                         eof_out,
  output logic                         bof_out,
  output logic [IW-1:0]                chainId_out
);

  logic [7:0]                   fw_q [MAX_CHAINS];
  logic [CW-1:0]                cnt [MAX_CHAINS];
  logic [N-1:0][DATA_WIDTH-1:0] elems [MAX_CHAINS];

  logic [CW-1:0]                cur_cnt;
  logic [CW-1:0]                idx;
  logic                         is_pack;
  logic                         pass_in;
  logic                         pack_in;
  logic                         last;
  logic                         emit_now;
  logic                         flush_only;
  logic                         cfg_hit;
  logic [N-1:0][DATA_WIDTH-1:0] packed_vec;

  always_comb begin
    cur_cnt    = cnt[chainId_in];
    is_pack    = fw_q[chainId_in] == FW_PACK;
    idx        = (valid_in && bof_in) ? '0 : cur_cnt;
    pass_in    = tracing && valid_in && !is_pack;
    pack_in    = tracing && valid_in && is_pack;
    last       = eof_in || (idx == CW'(N - 1));
    emit_now   = pack_in && last;
    flush_only = tracing && !valid_in && eof_in && is_pack
                 && (cur_cnt != '0);
    cfg_hit    = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
    packed_vec = '0;
    for (int e = 0; e < N; e++) begin
      if (CW'(e) < idx)
        packed_vec[e] = elems[chainId_in][e];
      else if (CW'(e) == idx && valid_in)
        packed_vec[e] = vector_in[0];
    end
  end

  for (genvar ch = 0; ch < MAX_CHAINS; ch++) begin : g_chain
    logic sel;
    assign sel = chainId_in == IW'(ch);

    scalar_pack_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (CW)
    ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .clear   (cfg_hit && sel),
      .store   (pack_in && sel),
      .emit    (last),
      .restart (bof_in),
      .flush   (flush_only && sel),
      .data    (vector_in[0]),
      .cnt     (cnt[ch]),
      .elems   (elems[ch])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHAINS; i++)
        fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else if (cfg_hit) begin
      fw_q[chainId_in] <= configData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out   <= 1'b0;
      vector_out  <= '0;
      count_out   <= '0;
      eof_out     <= 1'b0;
      bof_out     <= 1'b0;
      chainId_out <= '0;
    end else begin
      eof_out     <= eof_in;
      bof_out     <= bof_in;
      chainId_out <= chainId_in;
      valid_out   <= 1'b0;
      unique case (1'b1)
        pass_in: begin
          vector_out <= vector_in;
          count_out  <= CW'(N);
          valid_out  <= 1'b1;
        end
        emit_now: begin
          vector_out <= packed_vec;
          count_out  <= idx + CW'(1);
          valid_out  <= 1'b1;
        end
        flush_only: begin
          vector_out <= packed_vec;
          count_out  <= cur_cnt;
          valid_out  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
